// File: rtl/operand2_shift_unit.sv
// Multi-cycle ARM operand-2 barrel-shift replacement: decodes the shift encoding and shifts STEP bits per cycle.
// Optional macro OPSHIFT_FLUSH_EN adds a flush input that aborts the in-flight request.
module operand2_shift_unit #(
    parameter int unsigned STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef OPSHIFT_FLUSH_EN
    input  logic        flush,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_operand,
    input  logic [1:0]  in_type,
    input  logic        in_amt_reg,
    input  logic [7:0]  in_amount,
    input  logic        in_carry,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_carry
);

    localparam int unsigned CW = 6;
    localparam logic [1:0] T_LSL = 2'b00;
    localparam logic [1:0] T_LSR = 2'b01;
    localparam logic [1:0] T_ASR = 2'b10;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [31:0]     op_q, op_d;
    logic            carry_q, carry_d;
    logic [1:0]      type_q, type_d;
    logic            rrx_q, rrx_d;
    logic [CW-1:0]   rem_q, rem_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;

    logic [CW-1:0]   dec_n;
    logic            dec_rrx;
    logic [4:0]      amt5;
    logic [31:0]     sh_op;
    logic            sh_c;
    logic            sh_bit;
    logic [CW-1:0]   sh_rem;
    logic            flush_c;

`ifdef OPSHIFT_FLUSH_EN
    assign flush_c = flush;
`else
    assign flush_c = 1'b0;
`endif

    assign amt5 = in_amount[4:0];

    // Translate the ARM encoding into a count of single-bit shifts (33 forces a zero carry for LSL/LSR > 32)
    always_comb begin
        dec_n   = '0;
        dec_rrx = 1'b0;
        if (!in_amt_reg) begin
            case (in_type)
                T_LSL:        dec_n = CW'(amt5);
                T_LSR, T_ASR: dec_n = (amt5 == 5'd0) ? CW'(32) : CW'(amt5);
                default: begin
                    if (amt5 == 5'd0) begin
                        dec_rrx = 1'b1;
                        dec_n   = CW'(1);
                    end else begin
                        dec_n = CW'(amt5);
                    end
                end
            endcase
        end else if (in_amount != 8'd0) begin
            case (in_type)
                T_LSL, T_LSR: dec_n = (in_amount > 8'd33) ? CW'(33) : CW'(in_amount);
                T_ASR:        dec_n = (in_amount > 8'd32) ? CW'(32) : CW'(in_amount);
                default:      dec_n = (amt5 == 5'd0) ? CW'(32) : CW'(amt5);
            endcase
        end
    end

    // Up to STEP single-bit shifts of the latched type; carry keeps the last bit shifted out
    always_comb begin
        sh_op  = op_q;
        sh_c   = carry_q;
        sh_rem = rem_q;
        sh_bit = 1'b0;
        for (int unsigned i = 0; i < STEP; i++) begin
            if (sh_rem != '0) begin
                if (rrx_q) begin
                    sh_bit = sh_op[0];
                    sh_op  = {sh_c, sh_op[31:1]};
                    sh_c   = sh_bit;
                end else begin
                    case (type_q)
                        T_LSL: begin
                            sh_c  = sh_op[31];
                            sh_op = {sh_op[30:0], 1'b0};
                        end
                        T_LSR: begin
                            sh_c  = sh_op[0];
                            sh_op = {1'b0, sh_op[31:1]};
                        end
                        T_ASR: begin
                            sh_c  = sh_op[0];
                            sh_op = {sh_op[31], sh_op[31:1]};
                        end
                        default: begin
                            sh_c  = sh_op[0];
                            sh_op = {sh_op[0], sh_op[31:1]};
                        end
                    endcase
                end
                sh_rem = sh_rem - CW'(1);
            end
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        carry_d     = carry_q;
        type_d      = type_q;
        rrx_d       = rrx_q;
        rem_d       = rem_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = in_operand;
                    carry_d = in_carry;
                    type_d  = in_type;
                    rrx_d   = dec_rrx;
                    rem_d   = dec_n;
                    state_d = (dec_n == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                op_d    = sh_op;
                carry_d = sh_c;
                rem_d   = sh_rem;
                if (sh_rem == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_c) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            carry_q     <= 1'b0;
            type_q      <= '0;
            rrx_q       <= 1'b0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            type_q      <= type_d;
            rrx_q       <= rrx_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = op_q;
    assign out_carry  = carry_q;

endmodule
